serial_bit_tx: RTL and testbench
================================

Name: serial_bit_tx

Overview:
- Parallel-to-serial transmitter. Drives the single-bit serial line that the team's flip-flop/receiver blocks sample on their d input.
- Loads a WIDTH-bit word on a start request and shifts it out LSB-first inside a framed sequence: start bit (0), data bits, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Sits at the transmit end of the 1-bit link. It also replaces hand-written d stimulus in benches.

Parameters:
- WIDTH, 8, number of data bits per frame (≥1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (≥1).

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- start  input  1  transmit request, sampled on the rising clock edge.
- data_in  input  WIDTH  word to send; captured when start is accepted.
- tx_d  output  1  serial line, registered; idle level 1.
- busy  output  1  1 while a frame is in progress.
- done  output  1  single-cycle pulse when the stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, tx_d=1, busy=0, done=0, bit counter=0, clock-divider counter=0, shift register=0. Outputs take these values without waiting for a clock edge. Deassertion is sampled synchronously; the first active edge after reset=1 evaluates IDLE.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx_d=1, busy=0.
  - On an edge with start=1: latch data_in into the shift register, go to START, set busy=1 and tx_d=0 on that same edge.
- START:
  - tx_d=0 for exactly CLKS_PER_BIT cycles.
  - Then go to DATA with tx_d=shift[0] and bit counter=0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - After each bit, shift right and increment the bit counter.
  - After bit WIDTH-1 completes, go to STOP with tx_d=1.
- STOP:
  - tx_d=1 for CLKS_PER_BIT cycles.
  - Then go to IDLE: busy=0, done=1 for exactly one cycle.
- Latency and frame timing:
  - tx_d falls on the edge that accepts start.
  - Total frame is (WIDTH+2)*CLKS_PER_BIT cycles from that edge to the edge where busy falls.
  - done and busy=0 assert on the same edge.
- start while busy=1: ignored, no queuing. data_in changes during a frame have no effect.
- Back-to-back frames: start=1 in the cycle where done=1 (state IDLE) is accepted. The next frame's start bit begins on that edge with no idle gap.
- Divider counter:
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at every bit boundary, and is held at 0 in IDLE.
  - CLKS_PER_BIT=1: one bit per cycle, no stall cycles.
- Bit counter width: clog2(WIDTH) bits minimum, with no wrap inside a frame.
- Reset mid-frame: the frame is aborted and tx_d returns to 1 immediately. No done pulse is produced. The next accepted start begins a fresh frame.
- No X on any output after the first reset assertion.

Test Plan:
- Reset: hold reset=0 for 5 time units with clock running → tx_d=1, busy=0, done=0, even before any clock edge. Release reset: outputs stay idle while start=0.
- Single frame, WIDTH=8, CLKS_PER_BIT=4, data_in=8'hA5, start pulsed for 1 cycle:
  - tx_d sequence per 4-cycle slot is 0,1,0,1,0,0,1,0,1,1 (start bit, 8 data bits LSB-first, stop bit).
  - busy is high for exactly 40 cycles; done pulses once on the busy-fall edge.
- Ignored start: start=1 with data_in=8'hFF at cycle 10 of an 8'h3C frame → the transmitted bits are still 8'h3C's; only one done pulse occurs.
- Back-to-back: start held 1 with data_in=8'h01 then 8'h80 → the second start bit begins on the done edge. Total busy is 80 cycles with one 1-cycle low gap, and two done pulses.
- Mid-frame reset: assert reset=0 during data bit 3 of 8'h55 → tx_d=1 and busy=0 immediately, and no done pulse. A new start with 8'hAA sends a correct full frame.
- CLKS_PER_BIT=1, WIDTH=4, data_in=4'b1001 → tx_d over 6 consecutive cycles is 0,1,0,0,1,1; done fires in cycle 6.

Source files
------------

// File: rtl/serial_bit_tx.sv
`timescale 1ns / 1ps
// serial_bit_tx: parallel-to-serial transmitter for the 1-bit link.
// Sends a framed word LSB-first: start bit (0), WIDTH data bits, stop bit (1).
// Each serial bit is held for CLKS_PER_BIT clocks.
//
// Ports:
//   clock    rising-edge clock for all state
//   reset    asynchronous active-low reset
//   start    transmit request, accepted only while idle
//   data_in  word to send, captured on the accepting edge
//   tx_d     registered serial line, idles high
//   busy     high while a frame is in progress
//   done     one-cycle pulse on the edge the stop bit completes
module serial_bit_tx #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             tx_d,
   output logic             busy,
   output logic             done
);

   // Keep both counters at least one bit wide so the degenerate
   // WIDTH=1 / CLKS_PER_BIT=1 configurations still elaborate.
   localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } state_e;

   state_e           state_q;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] bit_q;
   logic [WIDTH-1:0] shift_q;

   logic             bit_end;
   logic [WIDTH-1:0] shift_next;

   // Last clock of the current serial bit.
   assign bit_end    = (div_q == DIV_LAST);
   assign shift_next = shift_q >> 1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_d    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               div_q <= '0;
               if (start) begin
                  // Start bit goes out on the accepting edge itself.
                  shift_q <= data_in;
                  bit_q   <= '0;
                  state_q <= StStart;
                  busy    <= 1'b1;
                  tx_d    <= 1'b0;
               end else begin
                  tx_d <= 1'b1;
                  busy <= 1'b0;
               end
            end

            StStart: begin
               if (bit_end) begin
                  div_q   <= '0;
                  bit_q   <= '0;
                  tx_d    <= shift_q[0];
                  state_q <= StData;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            StData: begin
               if (bit_end) begin
                  div_q <= '0;
                  if (bit_q == BIT_LAST) begin
                     tx_d    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     // Present the next bit straight from the shifted value.
                     shift_q <= shift_next;
                     tx_d    <= shift_next[0];
                     bit_q   <= bit_q + 1'b1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            StStop: begin
               if (bit_end) begin
                  div_q   <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            default: begin
               state_q <= StIdle;
               div_q   <= '0;
               tx_d    <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bit_tx.sv
`timescale 1ns / 1ps
// Bench for serial_bit_tx: DUT a (WIDTH=8, CLKS_PER_BIT=4) and
// DUT b (WIDTH=4, CLKS_PER_BIT=1) share clock and reset. Words are pushed
// to a per-DUT queue when a start is driven that must be accepted; a
// negedge monitor pops a word when busy rises and checks every frame cycle.
module tb_serial_bit_tx;

   logic       clk;
   logic       rst_n;
   logic       start_a, start_b;
   logic [7:0] data_a;
   logic [3:0] data_b;
   logic       tx_a, busy_a, done_a;
   logic       tx_b, busy_b, done_b;

   int checks;
   int errors;

   logic [7:0] qa[$];
   logic [7:0] qb[$];

   logic       active[2];
   logic       done_due[2];
   int         cyc[2];
   logic [7:0] word[2];
   logic [9:0] fbits[2];
   int         busy_cnt[2];
   int         done_cnt[2];

   serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) u_dut_a (
      .clock   (clk),
      .reset   (rst_n),
      .start   (start_a),
      .data_in (data_a),
      .tx_d    (tx_a),
      .busy    (busy_a),
      .done    (done_a)
   );

   serial_bit_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut_b (
      .clock   (clk),
      .reset   (rst_n),
      .start   (start_b),
      .data_in (data_b),
      .tx_d    (tx_b),
      .busy    (busy_b),
      .done    (done_b)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One monitor step per DUT at each falling edge.
   task automatic mon_step(input int id, input logic txd, input logic bsy, input logic dn);
      int   w, c, slot;
      logic expb;
      w = (id == 0) ? 8 : 4;
      c = (id == 0) ? 4 : 1;
      if (!rst_n) begin
         active[id]   = 1'b0;
         done_due[id] = 1'b0;
         check_eq($sformatf("dut%0d_rst_tx", id), txd, 1);
         check_eq($sformatf("dut%0d_rst_busy", id), bsy, 0);
         check_eq($sformatf("dut%0d_rst_done", id), dn, 0);
         return;
      end
      if (!active[id]) begin
         check_eq($sformatf("dut%0d_done", id), dn, done_due[id]);
         done_due[id] = 1'b0;
         if (bsy) begin
            if (id == 0 && qa.size() > 0) begin
               word[id] = qa.pop_front();
               active[id] = 1'b1;
               cyc[id] = 0;
            end else if (id == 1 && qb.size() > 0) begin
               word[id] = qb.pop_front();
               active[id] = 1'b1;
               cyc[id] = 0;
            end else begin
               check_eq($sformatf("dut%0d_unexpected_busy", id), bsy, 0);
            end
         end else begin
            check_eq($sformatf("dut%0d_idle_tx", id), txd, 1);
         end
      end
      if (active[id]) begin
         slot = cyc[id] / c;
         if (slot == 0) expb = 1'b0;
         else if (slot <= w) expb = word[id][slot-1];
         else expb = 1'b1;
         check_eq($sformatf("dut%0d_tx_slot%0d", id, slot), txd, expb);
         check_eq($sformatf("dut%0d_frame_busy", id), bsy, 1);
         if (cyc[id] > 0) check_eq($sformatf("dut%0d_frame_done", id), dn, 0);
         if (cyc[id] % c == 0) fbits[id][slot] = txd;
         cyc[id]++;
         if (cyc[id] == (w + 2) * c) begin
            active[id]   = 1'b0;
            done_due[id] = 1'b1;
         end
      end
      if (bsy) busy_cnt[id]++;
      if (dn) done_cnt[id]++;
   endtask

   always @(negedge clk) begin
      mon_step(0, tx_a, busy_a, done_a);
      mon_step(1, tx_b, busy_b, done_b);
   end

   task automatic clear_stats(input int id);
      busy_cnt[id] = 0;
      done_cnt[id] = 0;
      fbits[id]    = '0;
   endtask

   // Drives a one-cycle start; returns 1 time unit after the accepting edge.
   task automatic send_a(input logic [7:0] w);
      @(posedge clk);
      #1 start_a = 1'b1;
      data_a = w;
      qa.push_back(w);
      @(posedge clk);
      #1 start_a = 1'b0;
   endtask

   task automatic wait_done(input int id, input int limit, output int n);
      logic seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < limit) begin
         @(posedge clk);
         #1;
         n++;
         seen = (id == 0) ? done_a : done_b;
      end
      if (!seen) check_eq("wait_done_timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      data_a  = '0;
      data_b  = '0;
      for (int i = 0; i < 2; i++) begin
         active[i]   = 1'b0;
         done_due[i] = 1'b0;
         cyc[i]      = 0;
         word[i]     = '0;
         clear_stats(i);
      end

      // Asynchronous reset, observed before any clock edge.
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_async_tx", tx_a, 1);
      check_eq("rst_async_busy", busy_a, 0);
      check_eq("rst_async_done", done_a, 0);
      check_eq("rst_async_tx_b", tx_b, 1);
      #3 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("idle_after_rst_tx", tx_a, 1);
      check_eq("idle_after_rst_busy", busy_a, 0);

      // Single frame 8'hA5.
      clear_stats(0);
      send_a(8'hA5);
      check_eq("a5_first_tx", tx_a, 0);
      wait_done(0, 60, n);
      check_eq("a5_latency", n, 40);
      repeat (3) @(posedge clk);
      #1;
      check_eq("a5_busy_cycles", busy_cnt[0], 40);
      check_eq("a5_done_pulses", done_cnt[0], 1);
      check_eq("a5_frame_bits", fbits[0], 10'b1101001010);

      // Start with 8'hFF during an 8'h3C frame must be ignored.
      clear_stats(0);
      send_a(8'h3C);
      repeat (9) @(posedge clk);
      #1 start_a = 1'b1;
      data_a = 8'hFF;
      @(posedge clk);
      #1 start_a = 1'b0;
      wait_done(0, 60, n);
      repeat (5) @(posedge clk);
      #1;
      check_eq("ign_busy_cycles", busy_cnt[0], 40);
      check_eq("ign_done_pulses", done_cnt[0], 1);
      check_eq("ign_frame_bits", fbits[0], 10'b1001111000);

      // Back-to-back: start held high across the done cycle.
      clear_stats(0);
      @(posedge clk);
      #1 start_a = 1'b1;
      data_a = 8'h01;
      qa.push_back(8'h01);
      @(posedge clk);
      #1 data_a = 8'h80;
      qa.push_back(8'h80);
      wait_done(0, 60, n);
      check_eq("b2b_first_latency", n, 40);
      check_eq("b2b_gap_busy", busy_a, 0);
      @(posedge clk);
      #1 start_a = 1'b0;
      check_eq("b2b_second_busy", busy_a, 1);
      check_eq("b2b_second_start_bit", tx_a, 0);
      wait_done(0, 60, n);
      check_eq("b2b_second_latency", n, 40);
      repeat (4) @(posedge clk);
      #1;
      check_eq("b2b_busy_cycles", busy_cnt[0], 80);
      check_eq("b2b_done_pulses", done_cnt[0], 2);
      check_eq("b2b_second_bits", fbits[0], 10'b1100000000);

      // Reset during data bit 3 of 8'h55, then a clean 8'hAA frame.
      clear_stats(0);
      send_a(8'h55);
      repeat (17) @(posedge clk);
      #1;
      check_eq("midrst_bit3_tx", tx_a, 0);
      #1 rst_n = 1'b0;
      #1;
      check_eq("midrst_tx", tx_a, 1);
      check_eq("midrst_busy", busy_a, 0);
      check_eq("midrst_done", done_a, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("midrst_no_done", done_cnt[0], 0);
      clear_stats(0);
      send_a(8'hAA);
      wait_done(0, 60, n);
      check_eq("aa_latency", n, 40);
      repeat (3) @(posedge clk);
      #1;
      check_eq("aa_frame_bits", fbits[0], 10'b1101010100);
      check_eq("aa_done_pulses", done_cnt[0], 1);

      // One bit per clock: WIDTH=4, 4'b1001.
      clear_stats(1);
      @(posedge clk);
      #1 start_b = 1'b1;
      data_b = 4'b1001;
      qb.push_back(8'h09);
      @(posedge clk);
      #1 start_b = 1'b0;
      wait_done(1, 20, n);
      check_eq("b_latency", n, 6);
      repeat (3) @(posedge clk);
      #1;
      check_eq("b_frame_bits", fbits[1][5:0], 6'b110010);
      check_eq("b_busy_cycles", busy_cnt[1], 6);
      check_eq("b_done_pulses", done_cnt[1], 1);
      check_eq("queue_a_empty", qa.size(), 0);
      check_eq("queue_b_empty", qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
